// File: rtl/sram_sample_buffer.sv
// ---------------------------------------------------------------------------
// sram_sample_buffer
//
// Moves 16-bit audio samples from the I2S deserializer to the serializer
// through an external SRAM that is used as a circular FIFO. Only one SRAM
// access is in flight at a time, under a 7-state sequencer. When writes and
// reads are both pending, the sequencer grants them in round-robin order.
//
// Ports
//   clk, reset            system clock; synchronous active-high reset
//   flush                 clears pointers/count; takes effect only in IDLE
//   in_data/valid/ready   sample stream from the deserializer
//   out_data/valid/ready  sample stream to the serializer
//   address, rwb,         request to the SRAM controller (rwb: 1 = read,
//   write_data            0 = write)
//   read_data             data returned by the SRAM controller
//   fill_level/full/empty words currently stored in SRAM (0..DEPTH)
//
// Configuration macro
//   SRAM_BUF_OVERWRITE_EN  If defined, a write that arrives while the buffer
//                          is full drops the oldest sample. If undefined,
//                          upstream stalls while the buffer is full.
// ---------------------------------------------------------------------------
module sram_sample_buffer #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 262144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] address,
  output logic              rwb,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W:0]   fill_level,
  output logic              full,
  output logic              empty
);

`ifdef SRAM_BUF_OVERWRITE_EN
  localparam logic OVERWRITE_EN = 1'b1;
`else
  localparam logic OVERWRITE_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_SETUP,
    S_RD_WAIT,
    S_RD_CAPTURE
  } state_e;

  state_e              state_q,      state_d;
  logic                last_rd_q,    last_rd_d;     // last grant was a read
  logic                flush_pend_q, flush_pend_d;
  logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q,     rd_ptr_d;
  logic [ADDR_W:0]     fill_q,       fill_d;
  logic [DATA_W-1:0]   ib_q,         ib_d;
  logic                ib_valid_q,   ib_valid_d;
  logic [DATA_W-1:0]   ob_q,         ob_d;
  logic                ob_valid_q,   ob_valid_d;
  logic [ADDR_W-1:0]   address_q,    address_d;
  logic                rwb_q,        rwb_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;

  logic ib_take, ob_take, wr_req, rd_req;

  // The compare-and-clear wrap also handles a DEPTH that is not a power of two.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  assign full       = (fill_q == FILL_MAX);
  assign empty      = (fill_q == '0);
  assign fill_level = fill_q;
  assign out_data   = ob_q;
  assign out_valid  = ob_valid_q;
  assign address    = address_q;
  assign rwb        = rwb_q;
  assign write_data = write_data_q;

  // Reset is gated in so that upstream never sees a handshake while reset is held.
  assign in_ready = !reset && !ib_valid_q && (!full || OVERWRITE_EN);
  assign ib_take  = in_valid && in_ready;
  assign ob_take  = ob_valid_q && out_ready;
  assign wr_req   = ib_valid_q;
  // A read may start while ob is being consumed: ob is empty again before the capture.
  assign rd_req   = !empty && (!ob_valid_q || ob_take);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_rd_d    = last_rd_q;
    flush_pend_d = flush_pend_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    ib_d         = ib_q;
    ib_valid_d   = ib_valid_q;
    ob_d         = ob_q;
    ob_valid_d   = ob_valid_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    rwb_d        = 1'b1;

    if (ob_take) ob_valid_d = 1'b0;
    if (ib_take) begin
      ib_d       = in_data;
      ib_valid_d = 1'b1;
    end
    // A flush that arrives mid-access is remembered and then applied in IDLE.
    if (flush && state_q != S_IDLE) flush_pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          flush_pend_d = 1'b0;
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          fill_d       = '0;
          ib_valid_d   = 1'b0;
          ob_valid_d   = 1'b0;
        end else if (wr_req && (!rd_req || last_rd_q)) begin
          state_d      = S_WR_SETUP;
          address_d    = wr_ptr_q;
          write_data_d = ib_q;
          last_rd_d    = 1'b0;
        end else if (rd_req) begin
          state_d   = S_RD_SETUP;
          address_d = rd_ptr_q;
          last_rd_d = 1'b1;
        end
      end
      // rwb is registered, so it goes low during WR_PULSE only.
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        rwb_d   = 1'b0;
      end
      S_WR_PULSE: state_d = S_WR_HOLD;
      S_WR_HOLD: begin
        state_d    = S_IDLE;
        wr_ptr_d   = ptr_inc(wr_ptr_q);
        ib_valid_d = 1'b0;
        if (OVERWRITE_EN && full) rd_ptr_d = ptr_inc(rd_ptr_q);  // drop oldest
        else                      fill_d   = fill_q + (ADDR_W+1)'(1);
      end
      S_RD_SETUP: state_d = S_RD_WAIT;
      S_RD_WAIT:  state_d = S_RD_CAPTURE;
      S_RD_CAPTURE: begin
        state_d    = S_IDLE;
        ob_d       = read_data;
        ob_valid_d = 1'b1;
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        fill_d     = fill_q - (ADDR_W+1)'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_rd_q    <= 1'b1;      // write wins the first tie
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      ib_q         <= '0;
      ib_valid_q   <= 1'b0;
      ob_q         <= '0;
      ob_valid_q   <= 1'b0;
      address_q    <= '0;
      rwb_q        <= 1'b1;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      last_rd_q    <= last_rd_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      ib_q         <= ib_d;
      ib_valid_q   <= ib_valid_d;
      ob_q         <= ob_d;
      ob_valid_q   <= ob_valid_d;
      address_q    <= address_d;
      rwb_q        <= rwb_d;
      write_data_q <= write_data_d;
    end
  end

endmodule

// File: tb/tb_sram_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_sram_sample_buffer
//
// Bench for sram_sample_buffer with DEPTH = 8 and a behavioural SRAM model.
// The buffer's behaviour is modelled as a stream. The n-th sample written
// since reset or flush goes to address n mod DEPTH. Samples leave in arrival
// order, except in overwrite mode, where the oldest stored samples are lost.
// Build with +define+SRAM_BUF_OVERWRITE_EN to exercise the overwrite variant.
// ---------------------------------------------------------------------------
module tb_sram_sample_buffer;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] address;
  logic              rwb;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic [ADDR_W:0]   fill_level;
  logic              full;
  logic              empty;

  int checks = 0;
  int errors = 0;
  int wr_base = 0;   // writes since the last reset/flush

  always #5 clk = ~clk;

  sram_sample_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .address(address), .rwb(rwb), .write_data(write_data), .read_data(read_data),
    .fill_level(fill_level), .full(full), .empty(empty)
  );

  // Behavioural SRAM: data is written on the edge that ends the rwb-low cycle,
  // and reads are combinational.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  assign read_data = mem[address[2:0]];
  always @(posedge clk) if (rwb === 1'b0) mem[address[2:0]] <= write_data;

  // Transaction logs, filled by the monitors and inspected by the tests.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              shape_ok;  // address/data stable one cycle before and after the low cycle
  } wr_t;

  wr_t               wr_log[$];
  logic [DATA_W-1:0] out_log[$];
  logic [DATA_W-1:0] acc_log[$];

  initial begin : wr_monitor
    wr_t               cur;
    bit                pend;
    logic              prev_rwb;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    pend = 0; prev_rwb = 1'b1; prev_addr = '0; prev_wdata = '0; cur = '0;
    forever begin
      @(negedge clk); #1;
      if (pend) begin
        cur.shape_ok = cur.shape_ok && (rwb === 1'b1) && (address === cur.addr) &&
                       (write_data === cur.data);
        wr_log.push_back(cur);
        pend = 0;
      end
      if (rwb === 1'b0) begin
        cur.addr     = address;
        cur.data     = write_data;
        cur.shape_ok = (prev_rwb === 1'b1) && (prev_addr === address) && (prev_wdata === write_data);
        pend = 1;
      end
      prev_rwb = rwb; prev_addr = address; prev_wdata = write_data;
    end
  end

  initial begin : out_monitor
    forever begin
      @(negedge clk); #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) out_log.push_back(out_data);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // Offers one sample; returns on the clock edge that accepts it.
  task automatic push(input logic [DATA_W-1:0] d, input string tag);
    bit ok = 0;
    @(negedge clk); in_data = d; in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (in_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_push_timeout: in_ready stayed low for sample %h", tag, d);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc_log.push_back(d);
    end
  endtask

  task automatic stop_push();
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int c = 0;
    while (out_log.size() < n && c < 2000) begin @(negedge clk); c++; end
    #2;
    checks++;
    if (out_log.size() < n) begin
      errors++;
      $display("FAIL %s_out_timeout: got %0d outputs, want %0d", tag, out_log.size(), n);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete(); out_log.delete(); acc_log.delete();
  endtask

  // Compares the write log with the accepted samples: the n-th write goes to
  // address (wr_base + n) mod DEPTH with rwb low for exactly one cycle.
  task automatic check_writes(input string tag);
    checks++;
    if (wr_log.size() != acc_log.size()) begin
      errors++;
      $display("FAIL %s_wr_count: got %0d writes, want %0d", tag, wr_log.size(), acc_log.size());
    end
    for (int i = 0; i < wr_log.size() && i < acc_log.size(); i++) begin
      checks++;
      if (wr_log[i].addr !== ADDR_W'((wr_base + i) % DEPTH) || wr_log[i].data !== acc_log[i] ||
          wr_log[i].shape_ok !== 1'b1) begin
        errors++;
        $display("FAIL %s_wr[%0d]: got addr %0d data %h shape %b, want addr %0d data %h shape 1",
                 tag, i, wr_log[i].addr, wr_log[i].data, wr_log[i].shape_ok,
                 (wr_base + i) % DEPTH, acc_log[i]);
      end
    end
    wr_base += acc_log.size();
  endtask

  task automatic check_fifo_order(input string tag);
    checks++;
    if (out_log.size() != acc_log.size()) begin
      errors++;
      $display("FAIL %s_out_count: got %0d, want %0d", tag, out_log.size(), acc_log.size());
    end
    for (int i = 0; i < out_log.size() && i < acc_log.size(); i++) begin
      checks++;
      if (out_log[i] !== acc_log[i]) begin
        errors++;
        $display("FAIL %s_out[%0d]: got %h, want %h", tag, i, out_log[i], acc_log[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during: got %b, want 0", in_ready); end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || rwb !== 1'b1 || address !== '0 || write_data !== '0 ||
        out_data !== '0 || out_valid !== 1'b0 || fill_level !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got in_ready %b rwb %b addr %0d wdata %h odata %h ovalid %b fill %0d empty %b full %b, want 1 1 0 0000 0000 0 0 1 0",
               in_ready, rwb, address, write_data, out_data, out_valid, fill_level, empty, full);
    end
    wr_base = 0;
  endtask

  // Sample accepted on the edge that ends cycle 0, so out_valid must first be high in cycle 9.
  task automatic test_latency();
    clear_logs();
    @(negedge clk); out_ready = 1'b1;
    push(16'h1234, "lat");
    @(negedge clk); in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle8_valid: got %b, want 0", out_valid); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      errors++;
      $display("FAIL lat_cycle9: got valid %b data %h, want 1 1234", out_valid, out_data);
    end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (fill_level !== '0 || empty !== 1'b1) begin
      errors++; $display("FAIL lat_fill: got %0d empty %b, want 0 1", fill_level, empty);
    end
    check_writes("lat");
    check_fifo_order("lat");
  endtask

  task automatic test_back_to_back();
    clear_logs();
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(16'hA000 + 16'(i), "b2b");
    stop_push();
    wait_out(10, "b2b");
    repeat (4) @(negedge clk);
    check_writes("b2b");
    check_fifo_order("b2b");
  endtask

  // Random data and random backpressure; 20 samples also wrap the 8-word address space.
  task automatic test_random_wrap();
    clear_logs();
    fork
      begin
        for (int i = 0; i < 20; i++) push(16'($urandom), "rnd");
        stop_push();
      end
      begin
        for (int c = 0; c < 4000 && out_log.size() < 20; c++) begin
          @(negedge clk); out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk); out_ready = 1'b1;
    wait_out(20, "rnd");
    repeat (4) @(negedge clk);
    check_writes("rnd");
    check_fifo_order("rnd");
  endtask

`ifndef SRAM_BUF_OVERWRITE_EN
  // With out_ready low, the first sample parks in the output register and the
  // next DEPTH samples fill the SRAM; the sample after that must be stalled.
  task automatic test_full_stall();
    logic [DATA_W-1:0] last;
    clear_logs();
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(16'($urandom), "full");
    stop_push();
    repeat (8) @(negedge clk); #1;
    checks++;
    if (full !== 1'b1 || fill_level !== (ADDR_W+1)'(DEPTH) || empty !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: got full %b fill %0d empty %b in_ready %b, want 1 %0d 0 0",
               full, fill_level, empty, in_ready, DEPTH);
    end
    last = 16'($urandom);
    @(negedge clk); in_data = last; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL full_held[%0d]: in_ready got %b, want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    push(last, "full");
    stop_push();
    wait_out(DEPTH + 2, "full");
    repeat (4) @(negedge clk);
    check_writes("full");
    check_fifo_order("full");
  endtask
`else
  // The first sample parks in the output register; the rest overflow the SRAM,
  // and only the newest DEPTH of them survive.
  task automatic test_overwrite();
    logic [DATA_W-1:0] keep[$];
    logic [DATA_W-1:0] parked;
    clear_logs();
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push(16'($urandom), "ovw");
    stop_push();
    repeat (8) @(negedge clk); #1;
    checks++;
    if (full !== 1'b1 || fill_level !== (ADDR_W+1)'(DEPTH) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovw_state: got full %b fill %0d in_ready %b, want 1 %0d 1", full, fill_level, in_ready, DEPTH);
    end
    check_writes("ovw");
    parked = acc_log[0];
    for (int i = 1; i < acc_log.size(); i++) begin
      keep.push_back(acc_log[i]);
      if (keep.size() > DEPTH) void'(keep.pop_front());
    end
    keep.push_front(parked);
    @(negedge clk); out_ready = 1'b1;
    wait_out(DEPTH + 1, "ovw");
    repeat (10) @(negedge clk); #1;
    checks++;
    if (out_log.size() != keep.size() || fill_level !== '0) begin
      errors++;
      $display("FAIL ovw_drain: got %0d outputs fill %0d, want %0d outputs fill 0", out_log.size(), fill_level, keep.size());
    end
    for (int i = 0; i < out_log.size() && i < keep.size(); i++) begin
      checks++;
      if (out_log[i] !== keep[i]) begin errors++; $display("FAIL ovw_out[%0d]: got %h, want %h", i, out_log[i], keep[i]); end
    end
  endtask
`endif

  // Reset in the cycle where rwb is low must abort the write and discard all contents.
  task automatic test_reset_mid_write();
    int c = 0;
    clear_logs();
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(16'($urandom), "rst");
    push(16'hBEEF, "rst");
    stop_push();
    while (rwb !== 1'b0 && c < 50) begin @(negedge clk); #1; c++; end
    checks++;
    if (rwb !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: rwb got %b, want 0", rwb); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rwb !== 1'b1 || fill_level !== '0 || out_valid !== 1'b0 || empty !== 1'b1 || address !== '0) begin
      errors++;
      $display("FAIL rst_abort: got rwb %b fill %0d out_valid %b empty %b addr %0d, want 1 0 0 1 0",
               rwb, fill_level, out_valid, empty, address);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    wr_base = 0;
  endtask

  // A flush in RD_WAIT lets the read finish, then clears everything in IDLE.
  task automatic test_flush_mid_read();
    logic [DATA_W-1:0] s[3];
    for (int i = 0; i < 3; i++) s[i] = 16'($urandom);
    clear_logs();
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(s[i], "fl");
    stop_push();
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (fill_level !== (ADDR_W+1)'(2) || out_valid !== 1'b1) begin
      errors++; $display("FAIL fl_pre: got fill %0d out_valid %b, want 2 1", fill_level, out_valid);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (6) @(negedge clk); #1;
    checks++;
    if (out_log.size() != 2 || fill_level !== '0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fl_clear: got %0d outputs fill %0d empty %b out_valid %b, want 2 0 1 0",
               out_log.size(), fill_level, empty, out_valid);
    end
    for (int i = 0; i < out_log.size() && i < 2; i++) begin
      checks++;
      if (out_log[i] !== s[i]) begin errors++; $display("FAIL fl_out[%0d]: got %h, want %h", i, out_log[i], s[i]); end
    end
    clear_logs();
    wr_base = 0;
    push(16'h5A5A, "fl");
    stop_push();
    wait_out(1, "fl");
    repeat (4) @(negedge clk);
    check_writes("fl_after");
    check_fifo_order("fl_after");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_random_wrap();
`ifndef SRAM_BUF_OVERWRITE_EN
    test_full_stall();
`else
    test_overwrite();
`endif
    test_reset_mid_write();
    test_flush_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
